motor_drive_supervisor: RTL



---
 rtl/motor_supervisor_pkg.sv | 30 +++
 rtl/sup_timer.sv | 33 +++
 rtl/motor_drive_supervisor.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/motor_supervisor_pkg.sv
// motor_supervisor_pkg
// Shared types and constants for the motor drive supervisor slice.
//   sup_state_t      : 3-bit FSM state encoding, also driven out on the `state` port
//   TRIP_LOG_W       : width of the optional lifetime trip counter
//   state_drives_en  : true for the states in which the host requests reach the drivers
package motor_supervisor_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SOFTSTART = 3'd1,
    RUN       = 3'd2,
    TRIP      = 3'd3,
    COOLDOWN  = 3'd4,
    LOCKOUT   = 3'd5
  } sup_state_t;

  localparam int TRIP_LOG_W = 16;

  // Only SOFTSTART and RUN pass the host requests through to the motor enables.
  function automatic logic state_drives_en(input sup_state_t s);
    logic on;
    case (s)
      SOFTSTART: on = 1'b1;
      RUN:       on = 1'b1;
      default:   on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/sup_timer.sv
// sup_timer
// 32-bit loadable down-counter shared by every timed supervisor state.
// Counts down by one per cycle and holds at zero until reloaded.
//   clk, rst  : clock, asynchronous active-high reset (count cleared to 0)
//   load      : load `load_val` on the next edge (takes priority over counting)
//   load_val  : value to load
//   zero      : high while the count is 0
module sup_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        zero
);

  logic [31:0] count;

  // Down-counter with load priority, saturating at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end else begin
      count <= count;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/motor_drive_supervisor.sv
// motor_drive_supervisor
// Sole owner of the motor driver enables. Sequences the motors through
// IDLE -> SOFTSTART -> RUN, trips on over-current, enforces a cool-down,
// retries, and latches LOCKOUT after too many trips until `clear`.
// Optional feature macro: MOTOR_TRIP_LOG_EN adds the `trip_total` port and
// its 16-bit saturating lifetime trip counter.
//   clk, rst            : clock, asynchronous active-high reset
//   en_req_a, en_req_b  : host enable requests (levels)
//   oc_flag             : over-current indication (level, synchronous)
//   clear               : single-cycle pulse releasing LOCKOUT
//   en_a, en_b          : registered motor enables
//   state               : current FSM state (sup_state_t encoding)
//   lockout             : high while in LOCKOUT
//   retry_cnt           : trips since the last RUN window reset
//   trip_total          : lifetime trip count (MOTOR_TRIP_LOG_EN only)
module motor_drive_supervisor
  import motor_supervisor_pkg::*;
#(
  parameter int SOFTSTART_CYC = 1000,
  parameter int COOLDOWN_CYC  = 200000000,
  parameter int RETRY_MAX     = 3,
  parameter int WINDOW_CYC    = 1000000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_req_a,
  input  logic                           en_req_b,
  input  logic                           oc_flag,
  input  logic                           clear,
  output logic                           en_a,
  output logic                           en_b,
  output logic [2:0]                     state,
  output logic                           lockout,
  output logic [$clog2(RETRY_MAX+1)-1:0] retry_cnt
`ifdef MOTOR_TRIP_LOG_EN
  ,
  output logic [TRIP_LOG_W-1:0]          trip_total
`endif
);

  // The port width cannot always represent RETRY_MAX+1 (e.g. RETRY_MAX=3),
  // so the lockout decision uses a counter one value wider; the port shows
  // the same count clamped to what it can hold.
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int CW = $clog2(RETRY_MAX + 2);

  localparam logic [CW-1:0] RETRY_LIMIT = CW'(RETRY_MAX);
  localparam logic [CW-1:0] RETRY_SAT   = CW'(RETRY_MAX + 1);
  localparam logic [CW-1:0] PORT_MAX    = CW'((1 << RW) - 1);

  localparam logic [31:0] SS_LOAD  = 32'(SOFTSTART_CYC - 1);
  localparam logic [31:0] CD_LOAD  = 32'(COOLDOWN_CYC - 1);
  localparam logic [31:0] WIN_LOAD = 32'(WINDOW_CYC - 1);

  function automatic logic [CW-1:0] retry_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v >= RETRY_SAT) begin
      r = v;
    end else begin
      r = v + {{(CW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] retry_to_port(input logic [CW-1:0] v);
    logic [CW-1:0] c;
    if (v > PORT_MAX) begin
      c = PORT_MAX;
    end else begin
      c = v;
    end
    return c[RW-1:0];
  endfunction

  sup_state_t    cur_state;
  sup_state_t    nxt_state;
  logic [CW-1:0] retry_count;
  logic [CW-1:0] nxt_retry;
  logic          tmr_load;
  logic [31:0]   tmr_val;
  logic          tmr_zero;
  logic          any_req;

  assign any_req = en_req_a | en_req_b;
  assign state   = cur_state;

  sup_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, timer-load and retry decisions; oc_flag > request drop > timer expiry.
  always_comb begin
    nxt_state = cur_state;
    nxt_retry = retry_count;
    tmr_load  = 1'b0;
    tmr_val   = 32'd0;
    case (cur_state)
      IDLE: begin
        if (any_req && !oc_flag) begin
          nxt_state = SOFTSTART;
          tmr_load  = 1'b1;
          tmr_val   = SS_LOAD;
        end else begin
          nxt_state = IDLE;
        end
      end
      SOFTSTART: begin
        if (oc_flag) begin
          nxt_state = TRIP;
          nxt_retry = retry_inc(retry_count);
        end else if (!any_req) begin
          nxt_state = IDLE;
        end else if (tmr_zero) begin
          nxt_state = RUN;
          tmr_load  = 1'b1;
          tmr_val   = WIN_LOAD;
        end else begin
          nxt_state = SOFTSTART;
        end
      end
      RUN: begin
        if (oc_flag) begin
          nxt_state = TRIP;
          nxt_retry = retry_inc(retry_count);
        end else if (!any_req) begin
          nxt_state = IDLE;
        end else if (tmr_zero) begin
          // A full window of clean running forgives earlier trips.
          nxt_state = RUN;
          nxt_retry = {CW{1'b0}};
          tmr_load  = 1'b1;
          tmr_val   = WIN_LOAD;
        end else begin
          nxt_state = RUN;
        end
      end
      TRIP: begin
        // retry_count was already bumped on entry to TRIP.
        if (retry_count > RETRY_LIMIT) begin
          nxt_state = LOCKOUT;
        end else begin
          nxt_state = COOLDOWN;
          tmr_load  = 1'b1;
          tmr_val   = CD_LOAD;
        end
      end
      COOLDOWN: begin
        if (tmr_zero && !oc_flag) begin
          if (any_req) begin
            nxt_state = SOFTSTART;
            tmr_load  = 1'b1;
            tmr_val   = SS_LOAD;
          end else begin
            nxt_state = IDLE;
          end
        end else begin
          nxt_state = COOLDOWN;
        end
      end
      LOCKOUT: begin
        if (clear && !oc_flag) begin
          nxt_state = IDLE;
          nxt_retry = {CW{1'b0}};
        end else begin
          nxt_state = LOCKOUT;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_retry = retry_count;
      end
    endcase
  end

  // FSM state plus all outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= IDLE;
      en_a        <= 1'b0;
      en_b        <= 1'b0;
      lockout     <= 1'b0;
      retry_count <= {CW{1'b0}};
      retry_cnt   <= {RW{1'b0}};
    end else begin
      cur_state   <= nxt_state;
      en_a        <= state_drives_en(nxt_state) & en_req_a;
      en_b        <= state_drives_en(nxt_state) & en_req_b;
      lockout     <= (nxt_state == LOCKOUT);
      retry_count <= nxt_retry;
      retry_cnt   <= retry_to_port(nxt_retry);
    end
  end

`ifdef MOTOR_TRIP_LOG_EN
  // Lifetime trip counter: one count per TRIP entry, saturating, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trip_total <= {TRIP_LOG_W{1'b0}};
    end else if ((nxt_state == TRIP) && (cur_state != TRIP) &&
                 (trip_total != {TRIP_LOG_W{1'b1}})) begin
      trip_total <= trip_total + {{(TRIP_LOG_W-1){1'b0}}, 1'b1};
    end else begin
      trip_total <= trip_total;
    end
  end
`endif

endmodule
